// File: rtl/data_memory_unit_pkg.sv
// Shared types for the data-memory responder: access sizes, FSM states and
// the byte-lane mask helper used by the store path.
package data_memory_unit_pkg;

  typedef enum logic [1:0] {
    MEM_B   = 2'd0,
    MEM_H   = 2'd1,
    MEM_W   = 2'd2,
    MEM_RSV = 2'd3
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } dmem_state_t;

  // Little-endian lane selection; halves ignore addr[0] so a forced alignment falls out naturally.
  function automatic logic [3:0] lane_mask(input mem_size_t size, input logic [1:0] off);
    logic [3:0] mask;
    case (size)
      MEM_B:   mask = 4'b0001 << off;
      MEM_H:   mask = off[1] ? 4'b1100 : 4'b0011;
      default: mask = 4'b1111;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/data_memory_unit_if.sv
// Load/store request and response bundle between the execute stage and the
// data-memory responder.
interface data_memory_unit_if
  import data_memory_unit_pkg::*;
#(
  parameter int ADDR_W = 32
);

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  mem_size_t         req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/data_memory_unit_byte_ram.sv
// Synchronous single-port RAM, DEPTH words of four byte lanes, per-lane write
// enable and registered read data. Contents are never reset.
module byte_ram #(
  parameter int DEPTH = 1024,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             en_i,
  input  logic [3:0]       we_i,
  input  logic [IDX_W-1:0] addr_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o
);

  logic [3:0][7:0] mem_q [DEPTH];
  logic [31:0]     rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      for (int b = 0; b < 4; b++) begin
        if (we_i[b]) begin
          mem_q[addr_i][b] <= wdata_i[b*8 +: 8];
        end
      end
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_memory_unit.sv
// Byte-addressed data-memory responder: IDLE -> ACCESS -> RESP per request.
// Define DMEM_MISALIGN_TRAP_EN to flag misaligned half/word accesses instead of force-aligning them.
module data_memory_unit
  import data_memory_unit_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  data_memory_unit_if.slave dmem
);

  localparam int              IDX_W      = $clog2(DEPTH);
  localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W + 1)'(DEPTH * 4);

  dmem_state_t      state_q, state_d;
  logic             write_q;
  mem_size_t        size_q;
  logic             unsigned_q;
  logic [IDX_W+1:0] addr_q;
  logic [31:0]      wdata_q;
  logic             err_q, err_d;

  logic        accept;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic [31:0] shifted;
  logic [31:0] load_data;

  assign accept = (state_q == IDLE) && dmem.req_valid;

  always_comb begin
    err_d = 1'b0;
    if (dmem.req_size == MEM_RSV) begin
      err_d = 1'b1;
    end
    if ({1'b0, dmem.req_addr} >= ADDR_LIMIT) begin
      err_d = 1'b1;
    end
`ifdef DMEM_MISALIGN_TRAP_EN
    if ((dmem.req_size == MEM_H) && dmem.req_addr[0]) begin
      err_d = 1'b1;
    end
    if ((dmem.req_size == MEM_W) && (dmem.req_addr[1:0] != 2'b00)) begin
      err_d = 1'b1;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (dmem.req_valid) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_q    <= 1'b0;
      size_q     <= MEM_B;
      unsigned_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
    end else if (accept) begin
      write_q    <= dmem.req_write;
      size_q     <= dmem.req_size;
      unsigned_q <= dmem.req_unsigned;
      addr_q     <= dmem.req_addr[IDX_W+1:0];
      wdata_q    <= dmem.req_wdata;
      err_q      <= err_d;
    end
  end

  // Writes are gated by ACCESS so a reset before that edge aborts the store.
  assign ram_en = (state_q == ACCESS);
  assign ram_we = (ram_en && write_q && !err_q) ? lane_mask(size_q, addr_q[1:0]) : 4'b0000;

  always_comb begin
    case (size_q)
      MEM_B:   ram_wdata = {4{wdata_q[7:0]}};
      MEM_H:   ram_wdata = {2{wdata_q[15:0]}};
      default: ram_wdata = wdata_q;
    endcase
  end

  byte_ram #(
    .DEPTH (DEPTH)
  ) u_byte_ram (
    .clk_i   (clk),
    .en_i    (ram_en),
    .we_i    (ram_we),
    .addr_i  (addr_q[IDX_W+1:2]),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    shifted = ram_rdata >> {addr_q[1:0], 3'b000};
    case (size_q)
      MEM_B:   load_data = unsigned_q ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      MEM_H: begin
        if (addr_q[1]) begin
          load_data = unsigned_q ? {16'h0, ram_rdata[31:16]} : {{16{ram_rdata[31]}}, ram_rdata[31:16]};
        end else begin
          load_data = unsigned_q ? {16'h0, ram_rdata[15:0]} : {{16{ram_rdata[15]}}, ram_rdata[15:0]};
        end
      end
      default: load_data = ram_rdata;
    endcase
  end

  assign dmem.req_ready  = (state_q == IDLE);
  assign dmem.resp_valid = (state_q == RESP);
  assign dmem.resp_err   = (state_q == RESP) && err_q;
  assign dmem.resp_rdata = ((state_q == RESP) && !write_q && !err_q) ? load_data : 32'h0;

endmodule

// File: tb/tb_data_memory_unit.sv
// Directed self-checking bench for data_memory_unit: reset abort, extension,
// lane merging, range/size errors, misalignment and back-to-back throughput.
module tb_data_memory_unit;
  import data_memory_unit_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  data_memory_unit_if #(.ADDR_W(32)) dif ();

  data_memory_unit #(
    .DEPTH  (1024),
    .ADDR_W (32)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .dmem (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one request and waits (bounded) for its response; lat counts negedges after accept.
  task automatic do_req(input logic w, input mem_size_t sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
    int guard;
    @(negedge clk);
    dif.req_write    = w;
    dif.req_size     = sz;
    dif.req_unsigned = u;
    dif.req_addr     = a;
    dif.req_wdata    = wd;
    dif.req_valid    = 1'b1;
    guard = 0;
    while (!dif.req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    @(negedge clk);
    dif.req_valid = 1'b0;
    lat = 1;
    while (!dif.resp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    rd = dif.resp_rdata;
    er = dif.resp_err;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic        er;
    int          lat;
    checks++;
    if (dif.req_ready !== 1'b1 || dif.resp_valid !== 1'b0 || dif.resp_rdata !== 32'h0 || dif.resp_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_state: ready=%b valid=%b rdata=%h err=%b, want 1 0 0 0",
               dif.req_ready, dif.resp_valid, dif.resp_rdata, dif.resp_err);
    end
    do_req(1'b1, MEM_W, 1'b0, 32'h10, 32'hCAFEF00D, rd, er, lat);
    checks++;
    if (lat !== 2 || er !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_prestore: lat=%0d err=%b, want 2 0", lat, er);
    end
    @(negedge clk);
    dif.req_write    = 1'b1;
    dif.req_size     = MEM_W;
    dif.req_unsigned = 1'b0;
    dif.req_addr     = 32'h10;
    dif.req_wdata    = 32'h12345678;
    dif.req_valid    = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    dif.req_valid = 1'b0;
    checks++;
    if (dif.req_ready !== 1'b1 || dif.resp_valid !== 1'b0 || dif.resp_rdata !== 32'h0 || dif.resp_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_midaccess: ready=%b valid=%b rdata=%h err=%b, want 1 0 0 0",
               dif.req_ready, dif.resp_valid, dif.resp_rdata, dif.resp_err);
    end
    @(negedge clk);
    rst = 1'b0;
    do_req(1'b0, MEM_W, 1'b0, 32'h10, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'hCAFEF00D || er !== 1'b0 || lat !== 2) begin
      errors++;
      $display("[TB] FAIL reset_abort: rdata=%h err=%b lat=%0d, want cafef00d 0 2", rd, er, lat);
    end
  endtask

  task automatic test_extension();
    mem_size_t   sz  [4] = '{MEM_B, MEM_B, MEM_H, MEM_H};
    logic        un  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] ad  [4] = '{32'h23, 32'h23, 32'h20, 32'h22};
    logic [31:0] exp [4] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFBEEF, 32'h0000DEAD};
    logic [31:0] rd;
    logic        er;
    int          lat;
    do_req(1'b1, MEM_W, 1'b0, 32'h20, 32'hDEADBEEF, rd, er, lat);
    checks++;
    if (rd !== 32'h0 || er !== 1'b0 || lat !== 2) begin
      errors++;
      $display("[TB] FAIL ext_store: rdata=%h err=%b lat=%0d, want 0 0 2", rd, er, lat);
    end
    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, sz[i], un[i], ad[i], 32'h0, rd, er, lat);
      checks++;
      if (rd !== exp[i] || er !== 1'b0 || lat !== 2) begin
        errors++;
        $display("[TB] FAIL ext_load%0d: rdata=%h err=%b lat=%0d, want %h 0 2", i, rd, er, lat, exp[i]);
      end
    end
  endtask

  task automatic test_lane_merge();
    logic [31:0] rd;
    logic        er;
    int          lat;
    do_req(1'b1, MEM_W, 1'b0, 32'h40, 32'h00000000, rd, er, lat);
    do_req(1'b1, MEM_B, 1'b0, 32'h41, 32'hFFFFFFA5, rd, er, lat);
    do_req(1'b1, MEM_H, 1'b0, 32'h42, 32'hABCD1234, rd, er, lat);
    do_req(1'b0, MEM_W, 1'b0, 32'h40, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h1234A500 || er !== 1'b0) begin
      errors++;
      $display("[TB] FAIL lane_merge: rdata=%h err=%b, want 1234a500 0", rd, er);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd;
    logic        er;
    int          lat;
    do_req(1'b1, MEM_W, 1'b0, 32'h0, 32'h11223344, rd, er, lat);
    do_req(1'b1, MEM_W, 1'b0, 32'h1000, 32'h55555555, rd, er, lat);
    checks++;
    if (er !== 1'b1 || rd !== 32'h0 || lat !== 2) begin
      errors++;
      $display("[TB] FAIL err_range_store: err=%b rdata=%h lat=%0d, want 1 0 2", er, rd, lat);
    end
    do_req(1'b0, MEM_W, 1'b0, 32'h1000, 32'h0, rd, er, lat);
    checks++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      errors++;
      $display("[TB] FAIL err_range_load: err=%b rdata=%h, want 1 0", er, rd);
    end
    do_req(1'b1, MEM_RSV, 1'b0, 32'h0, 32'h66666666, rd, er, lat);
    checks++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      errors++;
      $display("[TB] FAIL err_size_store: err=%b rdata=%h, want 1 0", er, rd);
    end
    do_req(1'b0, MEM_W, 1'b0, 32'h0, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h11223344 || er !== 1'b0) begin
      errors++;
      $display("[TB] FAIL err_ram_unchanged: rdata=%h err=%b, want 11223344 0", rd, er);
    end
  endtask

  task automatic test_misalign();
    logic [31:0] rd;
    logic        er;
    int          lat;
    do_req(1'b0, MEM_W, 1'b0, 32'h22, 32'h0, rd, er, lat);
    checks++;
`ifdef DMEM_MISALIGN_TRAP_EN
    if (er !== 1'b1 || rd !== 32'h0) begin
      errors++;
      $display("[TB] FAIL misalign_lw: err=%b rdata=%h, want 1 0", er, rd);
    end
`else
    if (er !== 1'b0 || rd !== 32'hDEADBEEF) begin
      errors++;
      $display("[TB] FAIL misalign_lw: err=%b rdata=%h, want 0 deadbeef", er, rd);
    end
`endif
  endtask

  task automatic test_back_to_back();
    int acc [8];
    int rsp [8];
    int nacc;
    int nrsp;
    nacc = 0;
    nrsp = 0;
    @(negedge clk);
    dif.req_write    = 1'b0;
    dif.req_size     = MEM_W;
    dif.req_unsigned = 1'b0;
    dif.req_addr     = 32'h20;
    dif.req_wdata    = 32'h0;
    dif.req_valid    = 1'b1;
    for (int k = 0; k < 18; k++) begin
      if (nacc == 4) dif.req_valid = 1'b0;
      if (dif.resp_valid && nrsp < 8) begin
        rsp[nrsp] = k;
        nrsp++;
      end
      if (dif.req_valid && dif.req_ready && nacc < 4) begin
        acc[nacc] = k;
        nacc++;
      end
      @(negedge clk);
    end
    dif.req_valid = 1'b0;
    checks++;
    if (nacc !== 4 || nrsp !== 4) begin
      errors++;
      $display("[TB] FAIL b2b_counts: accepts=%0d responses=%0d, want 4 4", nacc, nrsp);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (acc[i] - acc[0] !== 3 * i || rsp[i] !== acc[i] + 2) begin
          errors++;
          $display("[TB] FAIL b2b_timing%0d: accept=%0d resp=%0d, want accept=%0d resp=%0d",
                   i, acc[i], rsp[i], acc[0] + 3 * i, acc[i] + 2);
        end
      end
    end
  endtask

  initial begin
    checks           = 0;
    errors           = 0;
    rst              = 1'b1;
    dif.req_valid    = 1'b0;
    dif.req_write    = 1'b0;
    dif.req_size     = MEM_B;
    dif.req_unsigned = 1'b0;
    dif.req_addr     = 32'h0;
    dif.req_wdata    = 32'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_extension();
    test_lane_merge();
    test_errors();
    test_misalign();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
